// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-requester AXI3 read arbiter.
// Optional round-robin arbitration is enabled with the AXI_RD_ARB_RR_EN macro.
package axi_rd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } arb_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam int         NUM_REQ        = 2;

endpackage

// File: rtl/axi_rd_arb_pick.sv
// Combinational two-way chooser. With AXI_RD_ARB_RR_EN defined a tie goes to the
// requester not granted last; otherwise m1 (data side) always wins a tie.
module axi_rd_arb_pick
   import axi_rd_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic               last,
   output logic               any,
   output logic               winner
);

   assign any = |valid;

`ifdef AXI_RD_ARB_RR_EN
   // A lone requester always wins; only a tie consults the pointer.
   assign winner = (&valid) ? ~last : valid[1];
`else
   logic unused_last;
   assign unused_last = last;
   assign winner      = valid[1];
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 AR/R channel pair between the I-cache refill port (m0) and the
// D-cache/uncached-load port (m1). AXI_RD_ARB_RR_EN selects round-robin arbitration.
module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              aclk,
   input  logic              aresetn,

   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [ADDR_W-1:0] m0_req_addr,
   input  logic [7:0]        m0_req_len,
   input  logic [2:0]        m0_req_size,
   output logic              m0_resp_valid,
   output logic [DATA_W-1:0] m0_resp_data,
   output logic              m0_resp_last,
   output logic              m0_resp_err,

   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic [7:0]        m1_req_len,
   input  logic [2:0]        m1_req_size,
   output logic              m1_resp_valid,
   output logic [DATA_W-1:0] m1_resp_data,
   output logic              m1_resp_last,
   output logic              m1_resp_err,

   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [1:0]        arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,

   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   arb_state_e          state;
   logic                grant;
   logic                last_grant;
   logic                any;
   logic                winner;
   logic                take;
   logic                in_data;
   logic [ADDR_W-1:0]   ar_addr;
   logic [7:0]          ar_len;
   logic [2:0]          ar_size;
   logic [NUM_REQ-1:0]  valid_vec;
   logic                unused_rid;

   assign valid_vec  = {m1_req_valid, m0_req_valid};
   assign unused_rid = ^rid;

   axi_rd_arb_pick u_pick (
      .valid  (valid_vec),
      .last   (last_grant),
      .any    (any),
      .winner (winner)
   );

`ifdef AXI_RD_ARB_RR_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         last_grant <= 1'b1;
      else if (state == IDLE && any)
         last_grant <= winner;
   end
`else
   assign last_grant = 1'b1;
`endif

   // NOTE: ready is qualified by aresetn so it reads 0 while reset is held, even
   // though the state register already sits in IDLE.
   assign take         = aresetn && (state == IDLE) && any;
   assign m0_req_ready = take & ~winner;
   assign m1_req_ready = take &  winner;

   always_ff @(posedge aclk or negedge aresetn) begin
      // NOTE: every register here uses <= so all updates see pre-edge values.
      if (!aresetn) begin
         state   <= IDLE;
         grant   <= 1'b0;
         ar_addr <= '0;
         ar_len  <= '0;
         ar_size <= '0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any) begin
               grant   <= winner;
               ar_addr <= winner ? m1_req_addr : m0_req_addr;
               ar_len  <= winner ? m1_req_len  : m0_req_len;
               ar_size <= winner ? m1_req_size : m0_req_size;
               arvalid <= 1'b1;
               state   <= ADDR;
            end
            ADDR: if (arready) begin
               arvalid <= 1'b0;
               rready  <= 1'b1;
               state   <= DATA;
            end
            DATA: if (rvalid && rlast) begin
               rready <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign arid    = ID_W'(grant);
   assign araddr  = ar_addr;
   assign arlen   = ar_len;
   assign arsize  = ar_size;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   // Routing follows grant alone; rid is deliberately ignored.
   assign in_data       = (state == DATA);
   assign m0_resp_valid = in_data & ~grant & rvalid;
   assign m1_resp_valid = in_data &  grant & rvalid;
   assign m0_resp_last  = in_data & ~grant & rlast;
   assign m1_resp_last  = in_data &  grant & rlast;
   assign m0_resp_err   = in_data & ~grant & (|rresp);
   assign m1_resp_err   = in_data &  grant & (|rresp);
   assign m0_resp_data  = rdata;
   assign m1_resp_data  = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus a random phase,
// compared each cycle against a transaction-level model of the arbiter.
module tb_axi_rd_arbiter;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
`ifdef AXI_RD_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic [1:0]        req_valid;
   logic [ADDR_W-1:0] req_addr [2];
   logic [7:0]        req_len  [2];
   logic [2:0]        req_size [2];
   logic [1:0]        req_ready, resp_valid, resp_last, resp_err;
   logic [DATA_W-1:0] resp_data [2];
   logic [ID_W-1:0]   arid, rid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize, arprot;
   logic [1:0]        arburst, arlock, rresp;
   logic [3:0]        arcache;
   logic              arvalid, arready, rlast, rvalid, rready;
   logic [DATA_W-1:0] rdata;

   always #5 aclk = ~aclk;

   axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m0_req_valid(req_valid[0]), .m0_req_ready(req_ready[0]), .m0_req_addr(req_addr[0]),
      .m0_req_len(req_len[0]), .m0_req_size(req_size[0]), .m0_resp_valid(resp_valid[0]),
      .m0_resp_data(resp_data[0]), .m0_resp_last(resp_last[0]), .m0_resp_err(resp_err[0]),
      .m1_req_valid(req_valid[1]), .m1_req_ready(req_ready[1]), .m1_req_addr(req_addr[1]),
      .m1_req_len(req_len[1]), .m1_req_size(req_size[1]), .m1_resp_valid(resp_valid[1]),
      .m1_resp_data(resp_data[1]), .m1_resp_last(resp_last[1]), .m1_resp_err(resp_err[1]),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one outstanding transaction, phase 0 = none, 1 = address, 2 = data.
   int phase, owner, last_grant, ar_wait, s_len, beat, cyc;
   logic [ADDR_W-1:0] cur_addr;
   logic [7:0]        cur_len;
   logic [2:0]        cur_size;
   int fixed_ar_delay, err_beat;
   bit r_gaps, stray, rand_req, rand_err;
   bit hold [2];
   int grants[$], accept_cyc[$], rlast_cyc[$];
   int beat_cnt [2], err_cnt [2], err_at [2], last_at [2];
   int arvalid_cnt, exp_beats_total;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_winner(input logic v0, input logic v1, input int lastg);
      if (!v0 && !v1) return -1;
      if (v0 && v1) return RR ? ((lastg == 1) ? 0 : 1) : 1;
      return v1 ? 1 : 0;
   endfunction

   task automatic set_req(input int n, input logic [ADDR_W-1:0] a, input logic [7:0] l,
                          input logic [2:0] s);
      req_valid[n] = 1'b1;
      req_addr[n]  = a;
      req_len[n]   = l;
      req_size[n]  = s;
   endtask

   task automatic new_req(input int n);
      set_req(n, $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
   endtask

   task automatic model_reset();
      phase = 0; owner = 0; last_grant = 1; beat = 0; s_len = 0; ar_wait = 0; cyc = 0;
      grants.delete(); accept_cyc.delete(); rlast_cyc.delete();
      for (int n = 0; n < 2; n++) begin
         beat_cnt[n] = 0; err_cnt[n] = 0; err_at[n] = -1; last_at[n] = -1; hold[n] = 1'b0;
      end
      arvalid_cnt = 0; exp_beats_total = 0;
      fixed_ar_delay = 0; err_beat = -1;
      r_gaps = 1'b0; stray = 1'b0; rand_req = 1'b0; rand_err = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_arvalid"}, arvalid, 0);
      check({tag, "_rready"}, rready, 0);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_resp_last_err"}, {resp_last, resp_err}, 0);
      check({tag, "_ar_regs"}, {arid, araddr, arlen, arsize}, 0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      req_valid = 2'b00; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      rdata = '0; rresp = 2'b00; rid = '0;
      for (int n = 0; n < 2; n++) set_req(n, '0, 8'd0, 3'd0);
      req_valid = 2'b00;
      model_reset();
      #3 check_reset_outs("reset");
      repeat (2) @(posedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   // One clock cycle: entered at posedge+1, drives the slave, samples at the
   // falling edge, advances the model on the rising edge.
   task automatic cycle();
      int w;
      int acc = -1;
      arready = (phase == 1) ? (ar_wait == 0) : 1'($urandom_range(0, 1));
      if (phase == 2) begin
         rvalid = r_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         rresp  = (beat == err_beat) ? 2'b10 :
                  (rand_err && $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rlast  = (beat == s_len);
      end else begin
         rvalid = stray;
         rresp  = 2'($urandom);
         rlast  = 1'($urandom);
      end
      rdata = $urandom;
      rid   = ID_W'($urandom);
      #4;
      w = (phase == 0) ? exp_winner(req_valid[0], req_valid[1], last_grant) : -1;
      for (int n = 0; n < 2; n++) begin
         check($sformatf("req_ready%0d", n), req_ready[n], w == n);
         check($sformatf("resp_valid%0d", n), resp_valid[n], phase == 2 && owner == n && rvalid);
         check($sformatf("resp_data%0d", n), resp_data[n], rdata);
         if (phase == 2 && owner == n && rvalid) begin
            check($sformatf("resp_last%0d", n), resp_last[n], rlast);
            check($sformatf("resp_err%0d", n), resp_err[n], rresp != 2'b00);
         end
         if (resp_valid[n]) begin
            if (resp_err[n]) begin err_cnt[n]++; err_at[n] = beat_cnt[n]; end
            if (resp_last[n]) last_at[n] = beat_cnt[n];
            beat_cnt[n]++;
         end
      end
      check("arvalid", arvalid, phase == 1);
      check("rready", rready, phase == 2);
      if (arvalid) arvalid_cnt++;
      if (phase == 1) begin
         s_len = int'(arlen);
         check("araddr", araddr, cur_addr);
         check("arlen", arlen, cur_len);
         check("arsize", arsize, cur_size);
         check("arid", arid, owner);
         check("ar_fixed", {arburst, arlock, arcache, arprot}, {2'b01, 9'b0});
      end
      @(posedge aclk);
      if (phase == 0) begin
         if (w >= 0) begin
            phase = 1; owner = w; last_grant = w; acc = w;
            cur_addr = req_addr[w]; cur_len = req_len[w]; cur_size = req_size[w];
            grants.push_back(w);
            accept_cyc.push_back(cyc);
            exp_beats_total += int'(req_len[w]) + 1;
            ar_wait = (fixed_ar_delay >= 0) ? fixed_ar_delay : $urandom_range(0, 3);
         end
      end else if (phase == 1) begin
         if (arready) begin phase = 2; beat = 0; end
         else if (ar_wait > 0) ar_wait--;
      end else if (rvalid) begin
         beat++;
         if (rlast) begin phase = 0; rlast_cyc.push_back(cyc); end
      end
      cyc++;
      #1;
      if (acc >= 0) begin
         if (hold[acc]) new_req(acc);
         else req_valid[acc] = 1'b0;
      end
      if (rand_req)
         for (int n = 0; n < 2; n++)
            if (!req_valid[n] && $urandom_range(0, 3) == 0) new_req(n);
   endtask

   task automatic run_until(input int ngr, input int budget, input string tag);
      int b = 0;
      while (!(grants.size() >= ngr && phase == 0)) begin
         if (b >= budget) begin
            check({tag, "_done"}, grants.size(), ngr);
            return;
         end
         cycle();
         b++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int b;
      // Single m0 burst with AR held off for two cycles.
      do_reset();
      fixed_ar_delay = 2;
      set_req(0, 32'h1c00_0000, 8'd3, 3'd2);
      run_until(1, 40, "single");
      check("single_arvalid_cycles", arvalid_cnt, 3);
      check("single_m0_beats", beat_cnt[0], 4);
      check("single_m0_last_at", last_at[0], 3);
      check("single_m1_beats", beat_cnt[1], 0);

      // Simultaneous requests straight after reset.
      do_reset();
      new_req(0);
      new_req(1);
      run_until(2, 60, "simul");
      if (grants.size() >= 2 && rlast_cyc.size() >= 1) begin
         check("simul_first", grants[0], RR ? 0 : 1);
         check("simul_second", grants[1], RR ? 1 : 0);
         check("simul_gap", accept_cyc[1], rlast_cyc[0] + 1);
      end else check("simul_grants", grants.size(), 2);

      // Error response on beat 2 of 4.
      do_reset();
      err_beat = 1;
      set_req(1, 32'h8000_0100, 8'd3, 3'd2);
      run_until(1, 40, "err");
      check("err_count", err_cnt[1], 1);
      check("err_beat", err_at[1], 1);
      check("err_beats", beat_cnt[1], 4);
      check("err_last_at", last_at[1], 3);

      // Stray R beats while idle and during the address phase.
      do_reset();
      stray = 1'b1;
      fixed_ar_delay = 3;
      repeat (3) cycle();
      set_req(0, 32'h0000_2000, 8'd1, 3'd2);
      run_until(1, 40, "stray");
      check("stray_m0_beats", beat_cnt[0], 2);
      check("stray_m1_beats", beat_cnt[1], 0);

      // Reset after the first beat of an 8-beat burst.
      do_reset();
      set_req(0, 32'h0000_4000, 8'd7, 3'd2);
      b = 0;
      while (beat_cnt[0] < 1 && b < 40) begin cycle(); b++; end
      check("mid_beat1", beat_cnt[0], 1);
      set_req(1, 32'h2000_0040, 8'd1, 3'd2);
      #2 aresetn = 1'b0;
      #1 check_reset_outs("midrst");
      model_reset();
      req_valid = 2'b00;
      rvalid = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      @(posedge aclk);
      #1;
      set_req(1, 32'h2000_0040, 8'd1, 3'd2);
      run_until(1, 40, "after_rst");
      if (grants.size() >= 1) check("after_rst_grant", grants[0], 1);
      check("after_rst_beats", beat_cnt[1], 2);
      check("after_rst_m0_beats", beat_cnt[0], 0);

      // m0 held continuously, m1 requests once.
      do_reset();
      hold[0] = 1'b1;
      new_req(0);
      new_req(1);
      run_until(3, 100, "b2b");
      hold[0] = 1'b0;
      req_valid[0] = 1'b0;
      if (grants.size() >= 3) begin
         check("b2b_g0", grants[0], RR ? 0 : 1);
         check("b2b_g1", grants[1], RR ? 1 : 0);
         check("b2b_g2", grants[2], 0);
      end else check("b2b_grants", grants.size(), 3);

      // Random traffic, then drain.
      do_reset();
      r_gaps = 1'b1; stray = 1'b1; rand_req = 1'b1; rand_err = 1'b1; fixed_ar_delay = -1;
      repeat (400) cycle();
      rand_req = 1'b0;
      b = 0;
      while ((phase != 0 || req_valid != 2'b00) && b < 400) begin cycle(); b++; end
      check("rand_drained", {phase != 0, req_valid}, 0);
      check("rand_beats", beat_cnt[0] + beat_cnt[1], exp_beats_total);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
